// File: rtl/mc8051_timing_ctrl.sv
// mc8051_timing_ctrl
// Machine-cycle phase sequencer and opcode-fetch front end. Steps the twelve
// phases S1_0..S6_1 of each machine cycle, stretches an instruction over
// 1-4 machine cycles, holds a phase while slow memory finishes, injects the
// interrupt LCALL opcode in place of the ROM byte and parks in an idle state.

module mc8051_timing_ctrl #(
    parameter logic [7:0] INT_OPCODE = 8'h12,
    parameter logic [3:0] IDLE_CODE  = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_rom_data,
    input  logic       i_mem_ready,
    input  logic       i_s2_fetch,
    input  logic       i_s3_fetch,
    input  logic [1:0] i_ncycles,
    input  logic       i_int_req,
    input  logic       i_idle,
    output logic [3:0] o_t_p_d,
    output logic [7:0] o_instr_buf,
    output logic [1:0] o_cycle_cnt,
    output logic       o_opcode_fetch,
    output logic       o_instr_start,
    output logic       o_instr_done,
    output logic       o_int_ack
);

    localparam logic [3:0] PH_S1_0 = 4'd0;
    localparam logic [3:0] PH_S1_1 = 4'd1;
    localparam logic [3:0] PH_S2_1 = 4'd3;
    localparam logic [3:0] PH_S3_1 = 4'd5;
    localparam logic [3:0] PH_S6_1 = 4'hB;

    typedef enum logic {
        ST_RUN,
        ST_IDLE
    } state_t;

    state_t     state;
    logic [3:0] phase;
    logic [1:0] cycle_cnt;
    logic [7:0] instr_buf;
    logic       int_inject;

    logic       running;
    logic       fetch_slot;
    logic       stall;
    logic       boundary;

    // Decode of the current phase: fetch slot, memory stall and instruction end
    always_comb begin
        running    = (state == ST_RUN);
        fetch_slot = running && (phase == PH_S1_1) && (cycle_cnt == 2'd0);
        // An injected opcode needs no ROM read, so the fetch slot never waits on it
        stall      = running && !i_mem_ready &&
                     ((fetch_slot && !int_inject) ||
                      ((phase == PH_S2_1) && i_s2_fetch) ||
                      ((phase == PH_S3_1) && i_s3_fetch));
        boundary   = running && (phase == PH_S6_1) && (cycle_cnt == i_ncycles);
    end

    // Phase/cycle sequencer, opcode latch, interrupt injection and idle FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            phase      <= PH_S1_0;
            cycle_cnt  <= 2'd0;
            instr_buf  <= 8'h00;
            int_inject <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!stall) begin
                        if (fetch_slot) begin
                            instr_buf  <= int_inject ? INT_OPCODE : i_rom_data;
                            int_inject <= 1'b0;
                        end
                        if (phase == PH_S6_1) begin
                            phase <= PH_S1_0;
                            if (cycle_cnt == i_ncycles) begin
                                cycle_cnt <= 2'd0;
                                // Interrupt outranks idle; the request is a level,
                                // so it is only looked at here at the boundary
                                if (i_int_req) begin
                                    int_inject <= 1'b1;
                                end else if (i_idle) begin
                                    state <= ST_IDLE;
                                end
                            end else begin
                                cycle_cnt <= cycle_cnt + 2'd1;
                            end
                        end else begin
                            phase <= phase + 4'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    // phase and cycle_cnt already sit at S1_0 / 0 from the boundary
                    if (i_int_req) begin
                        int_inject <= 1'b1;
                        state      <= ST_RUN;
                    end else if (!i_idle) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        o_t_p_d        = running ? phase : IDLE_CODE;
        o_instr_buf    = instr_buf;
        o_cycle_cnt    = cycle_cnt;
        o_opcode_fetch = fetch_slot && !int_inject;
        o_int_ack      = fetch_slot && int_inject;
        o_instr_start  = running && (phase == PH_S1_0) && (cycle_cnt == 2'd0);
        o_instr_done   = boundary;
    end

endmodule

// File: tb/tb_mc8051_timing_ctrl.sv
// Directed testbench for mc8051_timing_ctrl: phase stepping, multi-cycle
// instructions, memory stalls, interrupt injection, idle and mid-instruction reset.

module tb_mc8051_timing_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] i_rom_data;
    logic       i_mem_ready;
    logic       i_s2_fetch;
    logic       i_s3_fetch;
    logic [1:0] i_ncycles;
    logic       i_int_req;
    logic       i_idle;
    logic [3:0] o_t_p_d;
    logic [7:0] o_instr_buf;
    logic [1:0] o_cycle_cnt;
    logic       o_opcode_fetch;
    logic       o_instr_start;
    logic       o_instr_done;
    logic       o_int_ack;

    int n_assert = 0;
    int n_fail   = 0;

    mc8051_timing_ctrl #(
        .INT_OPCODE(8'h12),
        .IDLE_CODE (4'hF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_rom_data    (i_rom_data),
        .i_mem_ready   (i_mem_ready),
        .i_s2_fetch    (i_s2_fetch),
        .i_s3_fetch    (i_s3_fetch),
        .i_ncycles     (i_ncycles),
        .i_int_req     (i_int_req),
        .i_idle        (i_idle),
        .o_t_p_d       (o_t_p_d),
        .o_instr_buf   (o_instr_buf),
        .o_cycle_cnt   (o_cycle_cnt),
        .o_opcode_fetch(o_opcode_fetch),
        .o_instr_start (o_instr_start),
        .o_instr_done  (o_instr_done),
        .o_int_ack     (o_int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 2 time units after the rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic walk_to(input logic [3:0] p);
        int n;
        n = 0;
        while (o_t_p_d !== p && n < 200) begin
            step();
            n++;
        end
        chk("walk_to_phase", {4'h0, o_t_p_d}, {4'h0, p});
    endtask

    initial begin
        int fetches;
        int dones;
        int n;

        reset       = 1'b1;
        i_rom_data  = 8'hE4;
        i_mem_ready = 1'b1;
        i_s2_fetch  = 1'b0;
        i_s3_fetch  = 1'b0;
        i_ncycles   = 2'd0;
        i_int_req   = 1'b0;
        i_idle      = 1'b0;

        // ---- reset state ----
        step();
        chk("rst_tpd",   {4'h0, o_t_p_d}, 8'h00);
        chk("rst_buf",   o_instr_buf, 8'h00);
        chk("rst_cyc",   {6'h0, o_cycle_cnt}, 8'h00);
        chk("rst_fetch", {7'h0, o_opcode_fetch}, 8'h00);
        chk("rst_done",  {7'h0, o_instr_done}, 8'h00);
        chk("rst_ack",   {7'h0, o_int_ack}, 8'h00);
        reset = 1'b0;
        chk("rst_start", {7'h0, o_instr_start}, 8'h01);

        // ---- single-cycle instruction, ROM=E4 ----
        for (int k = 1; k <= 11; k++) begin
            step();
            chk("t1_phase", {4'h0, o_t_p_d}, 8'(k));
            chk("t1_fetch", {7'h0, o_opcode_fetch}, (k == 1) ? 8'h01 : 8'h00);
            chk("t1_done",  {7'h0, o_instr_done}, (k == 11) ? 8'h01 : 8'h00);
            chk("t1_start", {7'h0, o_instr_start}, 8'h00);
            if (k >= 2) chk("t1_buf", o_instr_buf, 8'hE4);
        end
        step();
        chk("t1_wrap",   {4'h0, o_t_p_d}, 8'h00);
        chk("t1_start2", {7'h0, o_instr_start}, 8'h01);

        // ---- four-cycle instruction (MUL/DIV), ROM=A4 ----
        i_ncycles  = 2'd3;
        i_rom_data = 8'hA4;
        fetches = 0;
        dones   = 0;
        for (int i = 0; i < 48; i++) begin
            chk("t2_phase", {4'h0, o_t_p_d}, 8'(i % 12));
            chk("t2_cyc",   {6'h0, o_cycle_cnt}, 8'(i / 12));
            if (o_opcode_fetch) fetches++;
            if (o_instr_done) dones++;
            if (i >= 2) chk("t2_buf", o_instr_buf, 8'hA4);
            if (i == 2) i_rom_data = 8'h55;
            step();
        end
        chk("t2_phase_end", {4'h0, o_t_p_d}, 8'h00);
        chk("t2_cyc_end",   {6'h0, o_cycle_cnt}, 8'h00);
        chk("t2_fetches",   8'(fetches), 8'h01);
        chk("t2_dones",     8'(dones), 8'h01);

        // ---- memory stalls in S1_1 and S3_1 ----
        i_ncycles  = 2'd0;
        i_rom_data = 8'hC3;
        n = 0;
        step(); n++;
        chk("t3_s11", {4'h0, o_t_p_d}, 8'h01);
        i_mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(); n++;
            chk("t3_hold_s11",  {4'h0, o_t_p_d}, 8'h01);
            chk("t3_fetch_hold", {7'h0, o_opcode_fetch}, 8'h01);
        end
        i_mem_ready = 1'b1;
        step(); n++;
        chk("t3_s20", {4'h0, o_t_p_d}, 8'h02);
        chk("t3_buf", o_instr_buf, 8'hC3);
        // Slow memory without a request must not hold S2_1 or other phases
        i_mem_ready = 1'b0;
        step(); n++;
        step(); n++;
        step(); n++;
        chk("t3_nostall", {4'h0, o_t_p_d}, 8'h05);
        i_s3_fetch = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); n++;
            chk("t3_hold_s31", {4'h0, o_t_p_d}, 8'h05);
        end
        i_mem_ready = 1'b1;
        step(); n++;
        i_s3_fetch = 1'b0;
        chk("t3_s40", {4'h0, o_t_p_d}, 8'h06);
        while (o_instr_done !== 1'b1 && n < 60) begin
            step(); n++;
        end
        chk("t3_done_clk", 8'(n), 8'd19);
        step();
        chk("t3_next", {4'h0, o_t_p_d}, 8'h00);

        // ---- interrupt injection ----
        i_rom_data = 8'hE4;
        walk_to(4'd6);
        i_int_req = 1'b1;
        walk_to(4'hB);
        chk("t4_done", {7'h0, o_instr_done}, 8'h01);
        step();
        chk("t4_start", {7'h0, o_instr_start}, 8'h01);
        chk("t4_ack0",  {7'h0, o_int_ack}, 8'h00);
        i_int_req = 1'b0;
        step();
        chk("t4_s11",   {4'h0, o_t_p_d}, 8'h01);
        chk("t4_nofetch", {7'h0, o_opcode_fetch}, 8'h00);
        chk("t4_ack",   {7'h0, o_int_ack}, 8'h01);
        // Injected fetch proceeds even with slow memory
        i_mem_ready = 1'b0;
        step();
        chk("t4_s20",  {4'h0, o_t_p_d}, 8'h02);
        chk("t4_buf",  o_instr_buf, 8'h12);
        chk("t4_ack_end", {7'h0, o_int_ack}, 8'h00);
        i_mem_ready = 1'b1;
        walk_to(4'h0);
        step();
        chk("t4_refetch", {7'h0, o_opcode_fetch}, 8'h01);
        chk("t4_noack",   {7'h0, o_int_ack}, 8'h00);
        step();
        chk("t4_rombuf", o_instr_buf, 8'hE4);

        // ---- idle, woken by interrupt ----
        i_idle = 1'b1;
        walk_to(4'hB);
        step();
        chk("t5_idle", {4'h0, o_t_p_d}, 8'h0F);
        chk("t5_idle_start", {7'h0, o_instr_start}, 8'h00);
        repeat (3) step();
        chk("t5_idle_hold",  {4'h0, o_t_p_d}, 8'h0F);
        chk("t5_idle_fetch", {7'h0, o_opcode_fetch}, 8'h00);
        chk("t5_idle_done",  {7'h0, o_instr_done}, 8'h00);
        i_int_req = 1'b1;
        step();
        chk("t5_wake", {4'h0, o_t_p_d}, 8'h00);
        chk("t5_wake_start", {7'h0, o_instr_start}, 8'h01);
        i_int_req = 1'b0;
        i_idle    = 1'b0;
        step();
        chk("t5_ack",     {7'h0, o_int_ack}, 8'h01);
        chk("t5_nofetch", {7'h0, o_opcode_fetch}, 8'h00);
        step();
        chk("t5_buf", o_instr_buf, 8'h12);

        // ---- idle, left by dropping i_idle ----
        i_idle = 1'b1;
        walk_to(4'hB);
        step();
        chk("t5b_idle", {4'h0, o_t_p_d}, 8'h0F);
        i_idle = 1'b0;
        step();
        chk("t5b_exit",  {4'h0, o_t_p_d}, 8'h00);
        chk("t5b_start", {7'h0, o_instr_start}, 8'h01);
        step();
        chk("t5b_fetch", {7'h0, o_opcode_fetch}, 8'h01);
        chk("t5b_noack", {7'h0, o_int_ack}, 8'h00);

        // ---- reset in S5_0 of cycle 2 ----
        i_ncycles  = 2'd3;
        i_rom_data = 8'hA4;
        step();
        chk("t6_buf", o_instr_buf, 8'hA4);
        n = 0;
        while (!(o_cycle_cnt === 2'd2 && o_t_p_d === 4'd8) && n < 100) begin
            step(); n++;
        end
        chk("t6_pre_cyc",   {6'h0, o_cycle_cnt}, 8'h02);
        chk("t6_pre_phase", {4'h0, o_t_p_d}, 8'h08);
        reset = 1'b1;
        #1;
        chk("t6_rst_tpd", {4'h0, o_t_p_d}, 8'h00);
        chk("t6_rst_cyc", {6'h0, o_cycle_cnt}, 8'h00);
        chk("t6_rst_buf", o_instr_buf, 8'h00);
        step();
        reset = 1'b0;
        chk("t6_start", {7'h0, o_instr_start}, 8'h01);
        step();
        chk("t6_fetch", {7'h0, o_opcode_fetch}, 8'h01);
        step();
        chk("t6_phase2", {4'h0, o_t_p_d}, 8'h02);
        chk("t6_newbuf", o_instr_buf, 8'hA4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
